// File: rtl/whirlpool_pkg.sv
// Shared Whirlpool constants and helpers: S-box, MixRows coefficients, round constants
// and the key-schedule state encoding.
package whirlpool_pkg;

   localparam int WP_ROUNDS = 10;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_EMIT = 1'b1;
   typedef enum logic {IDLE = ST_IDLE, EMIT = ST_EMIT} ks_state_t;

   // First row of the circulant MixRows matrix cir(1,1,4,1,8,5,2,9)
   localparam logic [63:0] WP_MIX_C = 64'h0101_0401_0805_0209;

   localparam logic [2047:0] WP_SBOX = {
      128'h1823c6e887b8014f36a6d2f5796f9152, 128'h60bc9b8ea30c7b351de0d7c22e4bfe57,
      128'h157737e59ff04ada58c9290ab1a06b85, 128'hbd5d10f4cb3e0567e427418ba77d95d8,
      128'hfbee7c66dd17479eca2dbf07ad5a8333, 128'h6302aa71c81949d9f2e35b889a2632b0,
      128'he90fd580becd3448ff7a905f20681aae, 128'hb454932264f173124008c3ecdba18d3d,
      128'h9700cf2b7682d61bb5af6a5045f330ef, 128'h3f55a2ea65ba2fc0de1cfd4d9275068a,
      128'hb2e60e1f62d4a896f9c525598472394c, 128'h5e78388cd1a5e261b3219c1e43c7fc04,
      128'h51996d0dfadf7e243babce118f4eb7eb, 128'h3c8194f7b9132cd3e76ec40356447fa9,
      128'h2abbc153dc0b9d6c3174f646ac8914e1, 128'h163a690970b6d0edcc4298a4285cf886
   };

   function automatic logic [7:0] wp_sbox(input logic [7:0] x);
      return WP_SBOX[2047 - 8*int'(x) -: 8];
   endfunction

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x^2 + 1
   function automatic logic [7:0] wp_xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
   endfunction

   function automatic logic [7:0] wp_gf_mul(input logic [7:0] a, input logic [7:0] c);
      logic [7:0] acc;
      logic [7:0] p;
      acc = '0;
      p   = a;
      for (int b = 0; b < 8; b++) begin
         if (c[b]) acc ^= p;
         p = wp_xtime(p);
      end
      return acc;
   endfunction

   function automatic logic [63:0] wp_rc(input logic [3:0] r);
      case (r)
         4'd1:    return 64'h1823c6e887b8014f;
         4'd2:    return 64'h36a6d2f5796f9152;
         4'd3:    return 64'h60bc9b8ea30c7b35;
         4'd4:    return 64'h1de0d7c22e4bfe57;
         4'd5:    return 64'h157737e59ff04ada;
         4'd6:    return 64'h58c9290ab1a06b85;
         4'd7:    return 64'hbd5d10f4cb3e0567;
         4'd8:    return 64'he427418ba77d95d8;
         4'd9:    return 64'hfbee7c66dd17479e;
         4'd10:   return 64'hca2dbf07ad5a8333;
         default: return 64'h0;
      endcase
   endfunction

endpackage

// File: rtl/whirlpool_key_schedule_if.sv
// Subkey stream from the key schedule (master) to the hash core (slave).
interface whirlpool_key_schedule_if;
   logic [511:0] o_subkey;
   logic         o_subkey_valid;
   logic         i_subkey_ready;
   logic [3:0]   o_round;

   modport master (output o_subkey, output o_subkey_valid, output o_round, input i_subkey_ready);
   modport slave  (input o_subkey, input o_subkey_valid, input o_round, output i_subkey_ready);
endinterface

// File: rtl/WHIRLPOOL_WCIPHER_ROUND.sv
// One combinational Whirlpool W-cipher round: SubBytes, ShiftColumns, MixRows, key add.
// State is row-major with row 0, byte 0 in [511:504].
module WHIRLPOOL_WCIPHER_ROUND
   import whirlpool_pkg::*;
(
   input  logic [511:0] i_state,
   input  logic [511:0] i_key,
   output logic [511:0] o_state
);
   logic [7:0] w_sub [64];
   logic [7:0] w_shf [64];

   for (genvar gi = 0; gi < 64; gi++) begin : g_sub
      assign w_sub[gi] = wp_sbox(i_state[511 - 8*gi -: 8]);
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_row
      for (genvar gj = 0; gj < 8; gj++) begin : g_col
         logic [7:0] w_mix;

         // Column j is rotated down by j rows
         assign w_shf[8*gi + gj] = w_sub[8*((gi - gj + 8) % 8) + gj];

         always_comb begin
            w_mix = '0;
            for (int k = 0; k < 8; k++) begin
               w_mix ^= wp_gf_mul(w_shf[8*gi + k], WP_MIX_C[63 - 8*((gj - k + 8) % 8) -: 8]);
            end
         end

         assign o_state[511 - 8*(8*gi + gj) -: 8] = w_mix ^ i_key[511 - 8*(8*gi + gj) -: 8];
      end
   end

endmodule

// File: rtl/whirlpool_key_schedule.sv
// Expands chaining key K0 into subkeys K1..K_ROUNDS (Kr = rho(Kr-1) ^ cr) and streams
// them one per cycle over a valid/ready handshake.
module whirlpool_key_schedule
   import whirlpool_pkg::*;
#(
   parameter int ROUNDS = WP_ROUNDS
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic [511:0]             i_key,
   whirlpool_key_schedule_if.master sk,
   output logic                     o_busy,
   output logic                     o_done
);
   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

   ks_state_t    r_state;
   logic [511:0] r_subkey;
   logic         r_valid;
   logic [3:0]   r_round;
   logic         r_busy;
   logic         r_done;

   logic [511:0] w_rho_in;
   logic [511:0] w_rho_out;
   logic [511:0] w_next_key;
   logic [3:0]   w_next_round;
   logic         w_xfer;

   // K0 feeds the round only for K1; every later subkey chains off the held one
   assign w_rho_in     = (r_state == IDLE) ? i_key : r_subkey;
   assign w_next_round = (r_state == IDLE) ? 4'd1 : r_round + 4'd1;
   assign w_next_key   = w_rho_out ^ {wp_rc(w_next_round), 448'd0};
   assign w_xfer       = r_valid & sk.i_subkey_ready;

   WHIRLPOOL_WCIPHER_ROUND u_rho (
      .i_state (w_rho_in),
      .i_key   (512'd0),
      .o_state (w_rho_out)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_subkey <= '0;
         r_valid  <= 1'b0;
         r_round  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_subkey <= w_next_key;
                  r_round  <= w_next_round;
                  r_valid  <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= EMIT;
               end
            end
            EMIT: begin
               if (w_xfer) begin
                  if (r_round == LAST_ROUND) begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_round <= '0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_subkey <= w_next_key;
                     r_round  <= w_next_round;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sk.o_subkey       = r_subkey;
   assign sk.o_subkey_valid = r_valid;
   assign sk.o_round        = r_round;
   assign o_busy            = r_busy;
   assign o_done            = r_done;

endmodule

// File: tb/tb_whirlpool_key_schedule.sv
// Testbench for whirlpool_key_schedule: directed vectors plus an independent reference
// (mini-box S-box construction, carry-less GF multiply) for full subkey sequences.
module tb_whirlpool_key_schedule;
   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [511:0] key;
   logic         busy;
   logic         done;
   logic [511:0] exp_k [1:10];
   int           n_checks = 0;
   int           n_pass = 0;

   whirlpool_key_schedule_if sk_if ();

   whirlpool_key_schedule #(.ROUNDS(10)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_key   (key),
      .sk      (sk_if),
      .o_busy  (busy),
      .o_done  (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // S-box built from the E, E^-1 and R mini-boxes
   function automatic logic [7:0] ref_sbox(input logic [7:0] x);
      logic [63:0] e_t;
      logic [63:0] ei_t;
      logic [63:0] r_t;
      logic [3:0]  a;
      logic [3:0]  b;
      logic [3:0]  t;
      e_t  = 64'h1B9CD6F3E874A250;
      ei_t = 64'hF0D7BE5A92C13486;
      r_t  = 64'h7CBDE49F638A2510;
      a = e_t[63 - 4*int'(x[7:4]) -: 4];
      b = ei_t[63 - 4*int'(x[3:0]) -: 4];
      t = r_t[63 - 4*int'(a ^ b) -: 4];
      return {e_t[63 - 4*int'(a ^ t) -: 4], ei_t[63 - 4*int'(b ^ t) -: 4]};
   endfunction

   function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011d << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [511:0] ref_rho(input logic [511:0] k);
      logic [7:0]   s [64];
      logic [7:0]   t [64];
      logic [63:0]  cvec;
      logic [7:0]   acc;
      logic [511:0] res;
      cvec = 64'h0101040108050209;
      for (int n = 0; n < 64; n++) s[n] = ref_sbox(k[511 - 8*n -: 8]);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) t[8*((i + j) % 8) + j] = s[8*i + j];
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            acc = '0;
            for (int m = 0; m < 8; m++) acc ^= ref_gmul(t[8*i + (j - m + 8) % 8], cvec[63 - 8*m -: 8]);
            res[511 - 8*(8*i + j) -: 8] = acc;
         end
      end
      return res;
   endfunction

   // Round constant r, row 0 = S-box entries 8(r-1)..8(r-1)+7
   task automatic model_schedule(input logic [511:0] k0);
      logic [511:0] k;
      k = k0;
      for (int r = 1; r <= 10; r++) begin
         k = ref_rho(k);
         for (int j = 0; j < 8; j++) k[511 - 8*j -: 8] ^= ref_sbox(8'(8*(r - 1) + j));
         exp_k[r] = k;
      end
   endtask

   function automatic logic [511:0] rand_key();
      logic [511:0] k;
      for (int w = 0; w < 16; w++) k[32*w +: 32] = $urandom();
      return k;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      sk_if.i_subkey_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (sk_if.o_subkey_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", sk_if.o_subkey_valid); else n_pass++;
      n_checks++; if (sk_if.o_round !== 4'd0) $display("FAIL reset_round got %0d want 0", sk_if.o_round); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_checks++; if (sk_if.o_subkey !== 512'd0) $display("FAIL reset_subkey got %h want 0", sk_if.o_subkey); else n_pass++;
   endtask

   task automatic test_idle_ready();
      do_reset();
      sk_if.i_subkey_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++; if (sk_if.o_subkey_valid !== 1'b0 || sk_if.o_round !== 4'd0 || busy !== 1'b0)
            $display("FAIL idle_ready cycle %0d got valid=%b round=%0d busy=%b want 0/0/0", c, sk_if.o_subkey_valid, sk_if.o_round, busy);
         else n_pass++;
      end
   endtask

   task automatic test_zero_key();
      do_reset();
      key = '0;
      model_schedule(key);
      sk_if.i_subkey_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++; if (sk_if.o_subkey[511:448] !== 64'h300beec0af902967) $display("FAIL zero_k1_row0 got %h want 300beec0af902967", sk_if.o_subkey[511:448]); else n_pass++;
      n_checks++; if (sk_if.o_subkey[447:0] !== {56{8'h28}}) $display("FAIL zero_k1_rest got %h want all bytes 28", sk_if.o_subkey[447:0]); else n_pass++;
      for (int r = 1; r <= 10; r++) begin
         n_checks++; if (sk_if.o_round !== 4'(r)) $display("FAIL zero_round got %0d want %0d", sk_if.o_round, r); else n_pass++;
         n_checks++; if (sk_if.o_subkey_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL zero_flags r=%0d got valid=%b busy=%b done=%b want 1/1/0", r, sk_if.o_subkey_valid, busy, done);
         else n_pass++;
         n_checks++; if (sk_if.o_subkey !== exp_k[r]) $display("FAIL zero_subkey r=%0d got %h want %h", r, sk_if.o_subkey, exp_k[r]); else n_pass++;
         if (r == 2) begin
            n_checks++; if (sk_if.o_subkey[511:504] !== 8'h3b) $display("FAIL zero_k2_b00 got %h want 3b", sk_if.o_subkey[511:504]); else n_pass++;
            n_checks++; if (sk_if.o_subkey[447:440] !== 8'h44) $display("FAIL zero_k2_b10 got %h want 44", sk_if.o_subkey[447:440]); else n_pass++;
         end
         tick();
      end
      n_checks++; if (done !== 1'b1 || busy !== 1'b0 || sk_if.o_subkey_valid !== 1'b0 || sk_if.o_round !== 4'd0)
         $display("FAIL zero_done got done=%b busy=%b valid=%b round=%0d want 1/0/0/0", done, busy, sk_if.o_subkey_valid, sk_if.o_round);
      else n_pass++;
      tick();
      n_checks++; if (done !== 1'b0) $display("FAIL zero_done_pulse got %b want 0", done); else n_pass++;
   endtask

   task automatic test_random_keys();
      do_reset();
      sk_if.i_subkey_ready = 1'b1;
      for (int n = 0; n < 200; n++) begin
         key = rand_key();
         model_schedule(key);
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int r = 1; r <= 10; r++) begin
            n_checks++; if (sk_if.o_round !== 4'(r) || sk_if.o_subkey !== exp_k[r])
               $display("FAIL rand_subkey key=%0d r=%0d got round=%0d %h want %h", n, r, sk_if.o_round, sk_if.o_subkey, exp_k[r]);
            else n_pass++;
            tick();
         end
         n_checks++; if (done !== 1'b1) $display("FAIL rand_done key=%0d got %b want 1", n, done); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int   got;
      int   cyc;
      logic rdy;
      do_reset();
      key = rand_key();
      model_schedule(key);
      start = 1'b1;
      tick();
      start = 1'b0;
      got = 0;
      cyc = 0;
      while (got < 10 && cyc < 200) begin
         rdy = (cyc >= 2 && cyc < 7) ? 1'b0 : 1'($urandom_range(0, 1));
         sk_if.i_subkey_ready = rdy;
         n_checks++; if (sk_if.o_subkey_valid !== 1'b1 || sk_if.o_round !== 4'(got + 1))
            $display("FAIL bp_round cyc=%0d got valid=%b round=%0d want 1/%0d", cyc, sk_if.o_subkey_valid, sk_if.o_round, got + 1);
         else n_pass++;
         n_checks++; if (sk_if.o_subkey !== exp_k[got + 1]) $display("FAIL bp_subkey cyc=%0d got %h want %h", cyc, sk_if.o_subkey, exp_k[got + 1]); else n_pass++;
         tick();
         if (rdy) got++;
         cyc++;
      end
      n_checks++; if (got !== 10) $display("FAIL bp_timeout accepted %0d want 10", got); else n_pass++;
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL bp_done got done=%b busy=%b want 1/0", done, busy); else n_pass++;
      sk_if.i_subkey_ready = 1'b1;
   endtask

   task automatic test_start_busy();
      int           n_done;
      logic [511:0] key_b;
      do_reset();
      key = rand_key();
      model_schedule(key);
      sk_if.i_subkey_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_done = 0;
      for (int r = 1; r <= 10; r++) begin
         start = (r == 4);
         if (r == 4) key = rand_key();
         n_checks++; if (sk_if.o_round !== 4'(r) || sk_if.o_subkey !== exp_k[r])
            $display("FAIL busy_subkey r=%0d got round=%0d %h want %h", r, sk_if.o_round, sk_if.o_subkey, exp_k[r]);
         else n_pass++;
         if (done === 1'b1) n_done++;
         tick();
      end
      if (done === 1'b1) n_done++;
      n_checks++; if (done !== 1'b1) $display("FAIL busy_done got %b want 1", done); else n_pass++;
      key_b = rand_key();
      key = key_b;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (done === 1'b1) n_done++;
      n_checks++; if (n_done !== 1) $display("FAIL busy_done_count got %0d want 1", n_done); else n_pass++;
      model_schedule(key_b);
      n_checks++; if (sk_if.o_subkey_valid !== 1'b1 || sk_if.o_round !== 4'd1 || sk_if.o_subkey !== exp_k[1])
         $display("FAIL done_restart got valid=%b round=%0d %h want 1/1 %h", sk_if.o_subkey_valid, sk_if.o_round, sk_if.o_subkey, exp_k[1]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      key = rand_key();
      model_schedule(key);
      sk_if.i_subkey_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      n_checks++; if (sk_if.o_round !== 4'd6) $display("FAIL rm_pre_round got %0d want 6", sk_if.o_round); else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (sk_if.o_subkey_valid !== 1'b0 || busy !== 1'b0 || sk_if.o_round !== 4'd0 || done !== 1'b0)
         $display("FAIL rm_after got valid=%b busy=%b round=%0d done=%b want 0/0/0/0", sk_if.o_subkey_valid, busy, sk_if.o_round, done);
      else n_pass++;
      tick();
      n_checks++; if (done !== 1'b0 || sk_if.o_subkey_valid !== 1'b0) $display("FAIL rm_no_done got done=%b valid=%b want 0/0", done, sk_if.o_subkey_valid); else n_pass++;
      key = rand_key();
      model_schedule(key);
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++; if (sk_if.o_round !== 4'd1 || sk_if.o_subkey !== exp_k[1])
         $display("FAIL rm_restart got round=%0d %h want 1 %h", sk_if.o_round, sk_if.o_subkey, exp_k[1]);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      key = '0;
      sk_if.i_subkey_ready = 1'b0;
      test_reset();
      test_idle_ready();
      test_zero_key();
      test_random_keys();
      test_backpressure();
      test_start_busy();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
